// File: rtl/mul_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined Wallace multiplier.
// The layer/row functions size the generate chain of carry-save layers.
package mul_pkg;

  localparam int MUL_LAT   = 3;
  localparam int WIDTH_MIN = 4;
  localparam int WIDTH_MAX = 32;

  function automatic int csa_rows_out(input int n);
    return 32'sd2 * (n / 32'sd3) + (n % 32'sd3);
  endfunction

  function automatic int csa_layers(input int n);
    int r;
    int l;
    r = n;
    l = 32'sd0;
    while (r > 32'sd2) begin
      r = csa_rows_out(r);
      l = l + 32'sd1;
    end
    return l;
  endfunction

  function automatic int csa_rows_at(input int n, input int k);
    int r;
    r = n;
    for (int i = 0; i < k; i++) begin
      r = csa_rows_out(r);
    end
    return r;
  endfunction

  // Baugh-Wooley correction: ones at bit w and bit 2w-1
  function automatic logic [2*WIDTH_MAX-1:0] bw_const(input int w);
    logic [2*WIDTH_MAX-1:0] v;
    v = {(2*WIDTH_MAX){1'b0}};
    v[w] = 1'b1;
    v[2*w-1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/wallace_csa_layer.sv
// One combinational 3:2 carry-save layer: every full group of three rows becomes a
// sum row and a shifted carry row; leftover rows pass straight through.
module wallace_csa_layer
  import mul_pkg::*;
#(
  parameter int ROWS = 3,
  parameter int PW   = 16,
  localparam int OROWS = csa_rows_out(ROWS)
) (
  input  logic [ROWS*PW-1:0]  rows,
  output logic [OROWS*PW-1:0] sum_carry
);

  localparam int GROUPS = ROWS / 3;
  localparam int REM    = ROWS - 3 * GROUPS;

  for (genvar g = 0; g < GROUPS; g++) begin : g_fa
    logic [PW-1:0] x;
    logic [PW-1:0] y;
    logic [PW-1:0] w;
    logic [PW-2:0] maj;
    assign x   = rows[(3*g)*PW +: PW];
    assign y   = rows[(3*g+1)*PW +: PW];
    assign w   = rows[(3*g+2)*PW +: PW];
    // carry out of the top column falls off the 2W-bit product
    assign maj = (x[PW-2:0] & y[PW-2:0]) | (x[PW-2:0] & w[PW-2:0]) | (y[PW-2:0] & w[PW-2:0]);
    assign sum_carry[(2*g)*PW +: PW]   = x ^ y ^ w;
    assign sum_carry[(2*g+1)*PW +: PW] = {maj, 1'b0};
  end

  for (genvar r = 0; r < REM; r++) begin : g_pass
    assign sum_carry[(2*GROUPS+r)*PW +: PW] = rows[(3*GROUPS+r)*PW +: PW];
  end

endmodule

// File: rtl/wallace_mul_pipe.sv
// Three-stage pipelined Wallace-tree multiplier, signed (Baugh-Wooley) or unsigned per op,
// with valid/ready handshake; the whole pipe freezes when the output is held.
module wallace_mul_pipe
  import mul_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TAGW  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 sgn,
  input  logic [TAGW-1:0]      in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   z,
  output logic [TAGW-1:0]      out_tag
);

  localparam int PW  = 2 * WIDTH;
  localparam int N0  = WIDTH + 1;
  localparam int L   = csa_layers(N0);
  localparam int H   = (L + 1) / 2;
  localparam int RH  = csa_rows_at(N0, H);
  localparam logic [2*WIDTH_MAX-1:0] BWC = bw_const(WIDTH);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
    $error("wallace_mul_pipe: WIDTH out of range");
  end

  logic              adv;
  logic [PW-1:0]     bw_row;
  logic [N0*PW-1:0]  pp;
  logic [N0*PW-1:0]  pp_r;
  logic [RH*PW-1:0]  s2_next;
  logic [RH*PW-1:0]  s2_r;
  logic [2*PW-1:0]   fin;
  logic [PW-1:0]     z_next;
  logic              v1_r;
  logic              v2_r;
  logic [TAGW-1:0]   tag1_r;
  logic [TAGW-1:0]   tag2_r;

  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;
  assign bw_row   = BWC[PW-1:0];

  // Partial-product matrix; in signed mode the MSB row/column terms are inverted, corner kept
  always_comb begin
    pp = {(N0*PW){1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        pp[i*PW + i + j] = (a[j] & b[i]) ^ (sgn & ((j == WIDTH - 1) != (i == WIDTH - 1)));
      end
    end
    pp[WIDTH*PW +: PW] = sgn ? bw_row : {PW{1'b0}};
  end

  // Layers before H read the S1 matrix, layers from H on read the S2 rows
  for (genvar k = 0; k < L; k++) begin : g_layer
    localparam int RIN  = csa_rows_at(N0, k);
    localparam int ROUT = csa_rows_out(RIN);
    logic [RIN*PW-1:0]  lin;
    logic [ROUT*PW-1:0] lout;
    if (k == 0) begin : g_src_pp
      assign lin = pp_r;
    end else if (k == H) begin : g_src_s2
      assign lin = s2_r;
    end else begin : g_src_prev
      assign lin = g_layer[k-1].lout;
    end
    wallace_csa_layer #(.ROWS(RIN), .PW(PW)) u_csa (
      .rows      (lin),
      .sum_carry (lout)
    );
  end

  assign s2_next = g_layer[H-1].lout;
  assign fin     = g_layer[L-1].lout;
  assign z_next  = fin[PW-1:0] + fin[2*PW-1:PW];

  // Stage registers S1/S2/S3; all hold when the output is stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_r      <= 1'b0;
      v2_r      <= 1'b0;
      out_valid <= 1'b0;
      tag1_r    <= {TAGW{1'b0}};
      tag2_r    <= {TAGW{1'b0}};
      out_tag   <= {TAGW{1'b0}};
      pp_r      <= {(N0*PW){1'b0}};
      s2_r      <= {(RH*PW){1'b0}};
      z         <= {PW{1'b0}};
    end else if (adv) begin
      v1_r      <= in_valid;
      tag1_r    <= in_tag;
      pp_r      <= pp;
      v2_r      <= v1_r;
      tag2_r    <= tag1_r;
      s2_r      <= s2_next;
      out_valid <= v2_r;
      out_tag   <= tag2_r;
      z         <= z_next;
    end else begin
      v1_r      <= v1_r;
      v2_r      <= v2_r;
      out_valid <= out_valid;
    end
  end

endmodule

// File: tb/tb_wallace_mul_pipe.sv
// Directed bench for wallace_mul_pipe: W=8 latency/sign/throughput/backpressure/reset
// checks, then a randomised sweep of W=4,16,32 against a 64-bit reference product.
module tb_wallace_mul_pipe;
  import mul_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  int          n_checks = 0;
  int          n_fail = 0;

  logic        in_valid, in_ready, sgn, out_valid, out_ready;
  logic [7:0]  a, b;
  logic [3:0]  in_tag, out_tag;
  logic [15:0] z;

  wallace_mul_pipe #(.WIDTH(8), .TAGW(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .sgn(sgn), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .z(z), .out_tag(out_tag)
  );

  logic        sw_valid [3];
  logic        sw_ir [3];
  logic        sw_ov [3];
  logic [3:0]  sw_otag [3];
  logic [31:0] sw_a, sw_b;
  logic        sw_sgn;
  logic [3:0]  sw_tag;
  logic [7:0]  sw_z4;
  logic [31:0] sw_z16;
  logic [63:0] sw_z32;

  wallace_mul_pipe #(.WIDTH(4), .TAGW(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(sw_valid[0]), .in_ready(sw_ir[0]), .a(sw_a[3:0]),
    .b(sw_b[3:0]), .sgn(sw_sgn), .in_tag(sw_tag), .out_valid(sw_ov[0]),
    .out_ready(out_ready), .z(sw_z4), .out_tag(sw_otag[0])
  );
  wallace_mul_pipe #(.WIDTH(16), .TAGW(4)) dut16 (
    .clk(clk), .rst(rst), .in_valid(sw_valid[1]), .in_ready(sw_ir[1]), .a(sw_a[15:0]),
    .b(sw_b[15:0]), .sgn(sw_sgn), .in_tag(sw_tag), .out_valid(sw_ov[1]),
    .out_ready(out_ready), .z(sw_z16), .out_tag(sw_otag[1])
  );
  wallace_mul_pipe #(.WIDTH(32), .TAGW(4)) dut32 (
    .clk(clk), .rst(rst), .in_valid(sw_valid[2]), .in_ready(sw_ir[2]), .a(sw_a),
    .b(sw_b), .sgn(sw_sgn), .in_tag(sw_tag), .out_valid(sw_ov[2]),
    .out_ready(out_ready), .z(sw_z32), .out_tag(sw_otag[2])
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one W=8 op into an empty pipe and check it appears exactly MUL_LAT cycles later
  task automatic single(input logic [7:0] ia, input logic [7:0] ib, input logic is,
                        input logic [3:0] it, input logic [15:0] ez, input string nm);
    a = ia; b = ib; sgn = is; in_tag = it; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 1; c < MUL_LAT; c++) begin
      check({nm, " early valid"}, 64'(out_valid), 64'd0);
      tick();
    end
    check({nm, " valid"}, 64'(out_valid), 64'd1);
    check({nm, " z"}, 64'(z), 64'(ez));
    check({nm, " tag"}, 64'(out_tag), 64'(it));
  endtask

  // Behavioural reference: sign/zero-extend to 64 bits, multiply, keep 2w bits
  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                          input int w, input logic s);
    logic [63:0] ux, uy, mi, mo;
    mi = (64'd1 << w) - 64'd1;
    ux = {32'd0, x} & mi;
    uy = {32'd0, y} & mi;
    if (s && ux[w-1]) ux = ux | ~mi;
    if (s && uy[w-1]) uy = uy | ~mi;
    mo = (w == 32) ? {64{1'b1}} : ((64'd1 << (2*w)) - 64'd1);
    return (ux * uy) & mo;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    logic        rs, ov_s;
    logic [63:0] e, got;
    logic [3:0]  ot;
    int          w;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sgn = 1'b0;
    a = 8'd0; b = 8'd0; in_tag = 4'd0;
    sw_valid[0] = 1'b0; sw_valid[1] = 1'b0; sw_valid[2] = 1'b0;
    sw_a = 32'd0; sw_b = 32'd0; sw_sgn = 1'b0; sw_tag = 4'd0;
    tick(); tick();
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset z", 64'(z), 64'd0);
    check("reset out_tag", 64'(out_tag), 64'd0);
    rst = 1'b0;
    tick();
    check("idle in_ready", 64'(in_ready), 64'd1);
    check("idle in_ready w4", 64'(sw_ir[0]), 64'd1);
    check("idle in_ready w16", 64'(sw_ir[1]), 64'd1);
    check("idle in_ready w32", 64'(sw_ir[2]), 64'd1);

    single(8'd6, 8'd9, 1'b0, 4'h3, 16'd54, "u 6x9");
    single(8'd14, 8'd12, 1'b0, 4'h5, 16'd168, "u 14x12");
    single(8'hFF, 8'hFF, 1'b0, 4'hA, 16'hFE01, "u 255x255");
    single(8'h80, 8'h80, 1'b1, 4'h6, 16'h4000, "s 80x80");
    single(8'h7F, 8'h80, 1'b1, 4'h7, 16'hC080, "s 7Fx80");

    // signed then unsigned on consecutive cycles
    a = 8'hFF; b = 8'h01; sgn = 1'b1; in_tag = 4'h1; in_valid = 1'b1;
    tick();
    sgn = 1'b0; in_tag = 4'h2;
    tick();
    in_valid = 1'b0;
    tick();
    check("mix signed valid", 64'(out_valid), 64'd1);
    check("mix signed z", 64'(z), 64'hFFFF);
    check("mix signed tag", 64'(out_tag), 64'h1);
    tick();
    check("mix unsigned valid", 64'(out_valid), 64'd1);
    check("mix unsigned z", 64'(z), 64'h00FF);
    check("mix unsigned tag", 64'(out_tag), 64'h2);
    tick();
    check("mix drained", 64'(out_valid), 64'd0);

    // 16 back-to-back ops: op k = (k+1)*(k+3), tag k
    sgn = 1'b0;
    for (int i = 0; i < 18; i++) begin
      in_valid = (i < 16);
      a = 8'(i + 1); b = 8'(i + 3); in_tag = 4'(i);
      tick();
      if (i >= 2) begin
        check("b2b valid", 64'(out_valid), 64'd1);
        check("b2b z", 64'(z), 64'((i - 1) * (i + 1)));
        check("b2b tag", 64'(out_tag), 64'(i - 2));
      end
    end
    in_valid = 1'b0;
    tick();
    check("b2b drained", 64'(out_valid), 64'd0);

    // backpressure: fill with 200, 63, 600 then hold out_ready low for 5 cycles
    in_valid = 1'b1;
    a = 8'd10; b = 8'd20; in_tag = 4'd1; tick();
    a = 8'd7;  b = 8'd9;  in_tag = 4'd2; tick();
    a = 8'd200; b = 8'd3; in_tag = 4'd3; tick();
    a = 8'd5;  b = 8'd5;  in_tag = 4'd4;
    out_ready = 1'b0;
    #1;
    check("bp in_ready low", 64'(in_ready), 64'd0);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("bp in_ready", 64'(in_ready), 64'd0);
      check("bp valid", 64'(out_valid), 64'd1);
      check("bp z stable", 64'(z), 64'd200);
      check("bp tag stable", 64'(out_tag), 64'd1);
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("bp rel1 z", 64'(z), 64'd63);
    check("bp rel1 tag", 64'(out_tag), 64'd2);
    tick();
    check("bp rel2 z", 64'(z), 64'd600);
    check("bp rel2 tag", 64'(out_tag), 64'd3);
    tick();
    check("bp rel3 valid", 64'(out_valid), 64'd1);
    check("bp rel3 z", 64'(z), 64'd25);
    check("bp rel3 tag", 64'(out_tag), 64'd4);
    tick();
    check("bp drained", 64'(out_valid), 64'd0);

    // asynchronous reset with three ops in flight
    in_valid = 1'b1;
    a = 8'd3; b = 8'd3; in_tag = 4'd7; tick();
    in_tag = 4'd8; tick();
    in_tag = 4'd9; tick();
    in_valid = 1'b0;
    check("rst pre valid", 64'(out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("rst async valid", 64'(out_valid), 64'd0);
    check("rst async z", 64'(z), 64'd0);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("rst no stale", 64'(out_valid), 64'd0);
    end

    // width sweep with random operands
    for (int wi = 0; wi < 3; wi++) begin
      w = (wi == 0) ? 4 : ((wi == 1) ? 16 : 32);
      for (int n = 0; n < 6; n++) begin
        ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
        if (n == 0) begin ra = 32'hFFFF_FFFF; rb = 32'hFFFF_FFFF; end
        if (n == 1) begin ra = 32'h8000_0000 >> (32 - w); rb = ra; rs = 1'b1; end
        e = ref_mul(ra, rb, w, rs);
        sw_a = ra; sw_b = rb; sw_sgn = rs; sw_tag = 4'(n);
        sw_valid[wi] = 1'b1;
        tick();
        sw_valid[wi] = 1'b0;
        ov_s = 1'b0; got = 64'd0; ot = 4'd0;
        for (int c = 0; c < 8; c++) begin
          case (wi)
            0:       begin ov_s = sw_ov[0]; got = 64'(sw_z4);  ot = sw_otag[0]; end
            1:       begin ov_s = sw_ov[1]; got = 64'(sw_z16); ot = sw_otag[1]; end
            default: begin ov_s = sw_ov[2]; got = sw_z32;      ot = sw_otag[2]; end
          endcase
          if (ov_s) break;
          tick();
        end
        check($sformatf("sweep w%0d valid", w), 64'(ov_s), 64'd1);
        check($sformatf("sweep w%0d z %0h*%0h s%0d", w, ra, rb, rs), got, e);
        check($sformatf("sweep w%0d tag", w), 64'(ot), 64'(n));
        tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
